// File: rtl/haar_feature_eval.sv
// Haar-feature evaluator: fetches the integral-image corners of one feature window,
// forms the signed feature score and compares it against an adjustable threshold.
module haar_feature_eval #(
  parameter int II_WIDTH   = 160,
  parameter int II_HEIGHT  = 120,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 21,
  parameter int RD_LATENCY = 3,
  parameter int SCORE_W    = DATA_W + 3,
  parameter int THR_INIT   = 0,
  parameter int THR_STEP   = 100,
  parameter int THR_MAX    = 288000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [7:0]                win_x,
  input  logic [6:0]                win_y,
  input  logic [5:0]                cell_w,
  input  logic [5:0]                cell_h,
  input  logic                      increment_threshold,
  input  logic                      decrement_threshold,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      ready,
  output logic                      done,
  output logic                      detected,
  output logic                      range_err,
  output logic signed [SCORE_W-1:0] score,
  output logic signed [SCORE_W-1:0] threshold
);

  localparam int CW = 16;
  localparam logic signed [SCORE_W-1:0] L_STEP = SCORE_W'(THR_STEP);
  localparam logic signed [SCORE_W-1:0] L_MAX  = SCORE_W'(THR_MAX);
  localparam logic signed [SCORE_W-1:0] L_MIN  = -L_MAX;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_COMPUTE} state_t;

  state_t                      r_state, w_state_next;
  logic [1:0]                  r_mode;
  logic [7:0]                  r_x0;
  logic [6:0]                  r_y0;
  logic [5:0]                  r_w, r_h;
  logic [1:0]                  r_k;
  logic [3:0]                  r_idx;
  logic [ADDR_W-1:0]           r_row_base, r_col;
  logic [RD_LATENCY-1:0]       r_vld_pipe;
  logic [3:0]                  r_slot_pipe [RD_LATENCY];
  logic [DATA_W-1:0]           r_corner [9];
  logic signed [SCORE_W-1:0]   r_score, r_thr;
  logic                        r_done, r_detected, r_range_err;

  logic                        w_rd_en, w_ready;
  logic [2:0]                  w_ncols, w_nrows;
  logic [3:0]                  w_n;
  logic [CW-1:0]               w_max_col, w_max_row;
  logic                        w_range_bad, w_last_fetch, w_last_capture;
  logic signed [SCORE_W-1:0]   w_c [9];
  logic signed [SCORE_W-1:0]   w_score, w_thr_up, w_thr_dn;

  function automatic logic signed [SCORE_W-1:0] rect(
    input logic signed [SCORE_W-1:0] tl, tr, bl, br);
    return br - tr - bl + tl;
  endfunction

  // Corner grid shape per feature mode
  always_comb begin
    w_ncols = 3'd3;
    w_nrows = 3'd2;
    case (r_mode)
      2'd1:    begin w_ncols = 3'd2; w_nrows = 3'd3; end
      2'd2:    w_ncols = 3'd4;
      2'd3:    w_nrows = 3'd3;
      default: ;
    endcase
  end

  assign w_n         = {1'b0, w_ncols} * {1'b0, w_nrows};
  assign w_max_col   = CW'(r_x0) + CW'(w_ncols - 3'd1) * CW'(r_w);
  assign w_max_row   = CW'(r_y0) + CW'(w_nrows - 3'd1) * CW'(r_h);
  assign w_range_bad = (r_w == 6'd0) || (r_h == 6'd0) ||
                       (w_max_col > CW'(II_WIDTH - 1)) || (w_max_row > CW'(II_HEIGHT - 1));
  assign w_last_fetch   = (r_idx == w_n - 4'd1);
  assign w_last_capture = r_vld_pipe[RD_LATENCY-1] && (r_slot_pipe[RD_LATENCY-1] == w_n - 4'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_corner_ext
      assign w_c[gi] = {{(SCORE_W-DATA_W){1'b0}}, r_corner[gi]};
    end
  endgenerate

  // Slots are row-major: index = m*ncols + k
  always_comb begin
    w_score = '0;
    case (r_mode)
      2'd0: w_score = rect(w_c[0], w_c[1], w_c[3], w_c[4]) - rect(w_c[1], w_c[2], w_c[4], w_c[5]);
      2'd1: w_score = rect(w_c[0], w_c[1], w_c[2], w_c[3]) - rect(w_c[2], w_c[3], w_c[4], w_c[5]);
      2'd2: w_score = rect(w_c[0], w_c[1], w_c[4], w_c[5])
                    - rect(w_c[1], w_c[2], w_c[5], w_c[6]) - rect(w_c[1], w_c[2], w_c[5], w_c[6])
                    + rect(w_c[2], w_c[3], w_c[6], w_c[7]);
      default: w_score = rect(w_c[0], w_c[1], w_c[3], w_c[4]) + rect(w_c[4], w_c[5], w_c[7], w_c[8])
                       - rect(w_c[1], w_c[2], w_c[4], w_c[5]) - rect(w_c[3], w_c[4], w_c[6], w_c[7]);
    endcase
  end

  assign w_thr_up = r_thr + L_STEP;
  assign w_thr_dn = r_thr - L_STEP;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_CHECK;
      S_CHECK:   w_state_next = w_range_bad ? S_IDLE : S_FETCH;
      S_FETCH:   if (w_last_fetch) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_last_capture) w_state_next = S_COMPUTE;
      S_COMPUTE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = 1'b1;
      S_FETCH: w_rd_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= '0; r_x0 <= '0; r_y0 <= '0; r_w <= '0; r_h <= '0;
      r_k <= '0; r_idx <= '0; r_row_base <= '0; r_col <= '0;
      r_score <= '0; r_thr <= SCORE_W'(THR_INIT);
      r_done <= 1'b0; r_detected <= 1'b0; r_range_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode; r_x0 <= win_x; r_y0 <= win_y; r_w <= cell_w; r_h <= cell_h;
          end
          if (increment_threshold && !decrement_threshold && (w_thr_up < L_MAX))
            r_thr <= w_thr_up;
          else if (decrement_threshold && !increment_threshold && (w_thr_dn > L_MIN))
            r_thr <= w_thr_dn;
        end
        S_CHECK: begin
          r_row_base <= ADDR_W'(r_y0) * ADDR_W'(II_WIDTH);
          r_col      <= ADDR_W'(r_x0);
          r_k        <= '0;
          r_idx      <= '0;
          if (w_range_bad) begin
            r_done <= 1'b1; r_range_err <= 1'b1; r_detected <= 1'b0; r_score <= '0;
          end
        end
        S_FETCH: begin
          r_idx <= r_idx + 4'd1;
          if ({1'b0, r_k} == w_ncols - 3'd1) begin
            r_k        <= '0;
            r_col      <= ADDR_W'(r_x0);
            r_row_base <= r_row_base + ADDR_W'(r_h) * ADDR_W'(II_WIDTH);
          end else begin
            r_k   <= r_k + 2'd1;
            r_col <= r_col + ADDR_W'(r_w);
          end
        end
        S_COMPUTE: begin
          r_score     <= w_score;
          r_detected  <= (w_score > r_thr);
          r_range_err <= 1'b0;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read-return tracking; reset drops anything still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_slot_pipe[i] <= '0;
    end else begin
      r_vld_pipe     <= {r_vld_pipe[RD_LATENCY-1:0], w_rd_en} >> 0;
      r_slot_pipe[0] <= r_idx;
      for (int i = 1; i < RD_LATENCY; i++) r_slot_pipe[i] <= r_slot_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 9; i++)
      if (r_vld_pipe[RD_LATENCY-1] && (r_slot_pipe[RD_LATENCY-1] == 4'(i)))
        r_corner[i] <= data_in;
  end

  assign rd_en     = w_rd_en;
  assign rd_addr   = r_row_base + r_col;
  assign ready     = w_ready;
  assign done      = r_done;
  assign detected  = r_detected;
  assign range_err = r_range_err;
  assign score     = r_score;
  assign threshold = r_thr;

endmodule
